// File: rtl/soc_system_mem_stream_writer.sv
// Packs an 8-bit Avalon-ST byte stream little-endian into 32-bit words and writes them
// through an Avalon-MM master into the on-chip memory, starting at a given word address.
module soc_system_mem_stream_writer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 12288,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  byte_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_written,
  input  logic [7:0]            snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [3:0]            m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  input  logic                  m_waitrequest
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  localparam logic [ADDR_WIDTH+1:0] DEPTH_L = (ADDR_WIDTH+2)'(DEPTH);

  state_t                state, state_nx;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [1:0]            lane;
  logic [CNT_WIDTH:0]    nwords;
  logic [ADDR_WIDTH+1:0] range_sum;
  logic                  range_bad;
  logic                  accept;
  logic                  last_byte;
  logic                  wr_done;

  // Upper bits of nwords beyond the sum width can never fit in memory, so they flag an error too.
  always_comb begin
    nwords    = ({1'b0, byte_count} + (CNT_WIDTH+1)'(3)) >> 2;
    range_sum = {2'b00, base_addr} + nwords[ADDR_WIDTH+1:0];
    range_bad = (|nwords[CNT_WIDTH:ADDR_WIDTH+2]) || (range_sum > DEPTH_L);
  end

  assign accept       = (state == COLLECT) && snk_valid;
  assign last_byte    = (lane == 2'd3) || (remaining == CNT_WIDTH'(1));
  assign wr_done      = (state == WRITE) && !m_waitrequest;
  assign snk_ready    = (state == COLLECT);
  assign m_write      = (state == WRITE);
  assign m_chipselect = (state == WRITE);
  assign done         = (state == FINISH);
  assign busy         = (state == COLLECT) || (state == WRITE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ((byte_count == '0) || range_bad) ? FINISH : COLLECT;
      COLLECT: if (accept && last_byte) state_nx = WRITE;
      WRITE:   if (!m_waitrequest) state_nx = (remaining == '0) ? FINISH : COLLECT;
      FINISH:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      err           <= 1'b0;
      words_written <= '0;
      remaining     <= '0;
      lane          <= '0;
      m_address     <= '0;
      m_byteenable  <= '0;
      m_writedata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        if (byte_count == '0) begin
          err <= 1'b0;
        end else if (range_bad) begin
          err <= 1'b1;
        end else begin
          err           <= 1'b0;
          words_written <= '0;
          remaining     <= byte_count;
          lane          <= '0;
          m_address     <= base_addr;
          m_byteenable  <= '0;
          m_writedata   <= '0;
        end
      end
      if (accept) begin
        m_writedata[{lane, 3'b000} +: 8] <= snk_data;
        m_byteenable[lane]               <= 1'b1;
        lane                             <= lane + 2'd1;
        remaining                        <= remaining - CNT_WIDTH'(1);
      end
      // Completed write: advance and clear the packer so unused lanes of a short word stay 0.
      if (wr_done) begin
        m_address     <= m_address + ADDR_WIDTH'(1);
        words_written <= words_written + (ADDR_WIDTH+1)'(1);
        lane          <= '0;
        m_byteenable  <= '0;
        m_writedata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_mem_stream_writer.sv
// Directed bench for soc_system_mem_stream_writer: a queue of expected memory writes is
// filled as transfers are launched and drained by a monitor on completed Avalon-MM writes.
module tb_soc_system_mem_stream_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [15:0] byte_count = '0;
  logic        busy, done, err;
  logic [14:0] words_written;
  logic [7:0]  snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [13:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;

  soc_system_mem_stream_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .byte_count(byte_count),
    .busy(busy), .done(done), .err(err), .words_written(words_written),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // A write is committed at the rising edge following a cycle with m_write=1 and no wait.
  always @(negedge clk) begin
    if (!reset && m_write && !m_waitrequest) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL write_expected: unexpected write at %0h", m_address);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (m_address !== e.addr) begin
          errors++;
          $error("FAIL wr_addr: observed %0h expected %0h", m_address, e.addr);
        end
        checks++;
        if (m_writedata !== e.data) begin
          errors++;
          $error("FAIL wr_data: observed %0h expected %0h", m_writedata, e.data);
        end
        checks++;
        if (m_byteenable !== e.be) begin
          errors++;
          $error("FAIL wr_be: observed %0h expected %0h", m_byteenable, e.be);
        end
        checks++;
        if (m_chipselect !== 1'b1) begin
          errors++;
          $error("FAIL wr_cs: observed %0h expected 1", m_chipselect);
        end
      end
    end
  end

  task automatic push(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back('{addr: a, data: d, be: be});
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic do_start(input logic [13:0] b, input logic [15:0] c);
    base_addr  = b;
    byte_count = c;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 14'h3ABC;
    byte_count = 16'hFFFF;
  endtask

  // Called at posedge+1; returns at posedge+1 after the last byte is consumed.
  task automatic stream(input logic [7:0] first, input int n, input bit gaps);
    int  i = 0;
    int  cyc = 0;
    bit  tog = 1'b1;
    bit  consumed;
    while (i < n && cyc < 300) begin
      snk_valid = gaps ? tog : 1'b1;
      snk_data  = first + 8'(i);
      @(negedge clk);
      consumed = snk_valid && snk_ready;
      @(posedge clk); #1;
      if (consumed) i++;
      tog = !tog;
      cyc++;
    end
    snk_valid = 1'b0;
    check("stream_bytes", i, n);
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(input int limit);
    bit got = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
  endtask

  // Holds waitrequest (already 1) through three write cycles, checking the bus stays frozen.
  task automatic stall3();
    int n = 0;
    int g = 0;
    logic [13:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    while (n < 3 && g < 100) begin
      @(negedge clk);
      g++;
      if (m_write) begin
        if (n == 0) begin
          a0 = m_address; d0 = m_writedata; b0 = m_byteenable;
        end else begin
          check("stall_addr", m_address, a0);
          check("stall_data", m_writedata, d0);
          check("stall_be", m_byteenable, b0);
        end
        check("stall_ready", snk_ready, 1'b0);
        n++;
      end
    end
    check("stall_cycles", n, 3);
    @(posedge clk); #1;
    m_waitrequest = 1'b0;
  endtask

  initial begin
    int w0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ww", words_written, 15'd0);
    check("rst_ready", snk_ready, 1'b0);
    check("rst_write", m_write, 1'b0);
    check("rst_cs", m_chipselect, 1'b0);
    check("rst_addr", m_address, 14'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Full-word transfer
    w0 = wr_cnt;
    push(14'h0010, 32'h14131211, 4'b1111);
    push(14'h0011, 32'h18171615, 4'b1111);
    do_start(14'h0010, 16'd8);
    @(negedge clk);
    check("t1_busy", busy, 1'b1);
    check("t1_first_ready", snk_ready, 1'b1);
    @(posedge clk); #1;
    stream(8'h11, 8, 1'b0);
    wait_done(20);
    check("t1_ww", words_written, 15'd2);
    check("t1_err", err, 1'b0);
    check("t1_busy_end", busy, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_done_pulse", done, 1'b0);
    check("t1_writes", wr_cnt - w0, 2);
    @(posedge clk); #1;

    // Partial final word
    push(14'h0100, 32'hA3A2A1A0, 4'b1111);
    push(14'h0101, 32'h0000A5A4, 4'b0011);
    do_start(14'h0100, 16'd6);
    stream(8'hA0, 6, 1'b0);
    wait_done(20);
    check("t2_ww", words_written, 15'd2);
    @(posedge clk); #1;

    // Waitrequest stall on the first write
    w0 = wr_cnt;
    m_waitrequest = 1'b1;
    push(14'h0200, 32'h33323130, 4'b1111);
    push(14'h0201, 32'h37363534, 4'b1111);
    do_start(14'h0200, 16'd8);
    fork
      stream(8'h30, 8, 1'b0);
      stall3();
    join
    wait_done(20);
    check("t3_ww", words_written, 15'd2);
    check("t3_writes", wr_cnt - w0, 2);
    @(posedge clk); #1;

    // Range error
    w0 = wr_cnt;
    do_start(14'h2FFF, 16'd8);
    @(negedge clk);
    check("t4_done", done, 1'b1);
    check("t4_err", err, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_write", m_write, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_err_sticky", err, 1'b1);
    check("t4_writes", wr_cnt - w0, 0);

    // Exactly fits at the top of memory
    push(14'h2FFF, 32'h44434241, 4'b1111);
    do_start(14'h2FFF, 16'd4);
    check("t5_err_cleared", err, 1'b0);
    stream(8'h41, 4, 1'b0);
    wait_done(20);
    check("t5_ww", words_written, 15'd1);
    check("t5_err", err, 1'b0);
    @(posedge clk); #1;

    // Zero length
    w0 = wr_cnt;
    do_start(14'h0005, 16'd0);
    @(negedge clk);
    check("t6_done", done, 1'b1);
    check("t6_err", err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_writes", wr_cnt - w0, 0);

    // Reset after two bytes of the second word
    w0 = wr_cnt;
    push(14'h0020, 32'h53525150, 4'b1111);
    do_start(14'h0020, 16'd8);
    stream(8'h50, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t7_busy", busy, 1'b0);
    check("t7_ready", snk_ready, 1'b0);
    check("t7_write", m_write, 1'b0);
    check("t7_cs", m_chipselect, 1'b0);
    check("t7_be", m_byteenable, 4'b0000);
    check("t7_addr", m_address, 14'd0);
    check("t7_data", m_writedata, 32'd0);
    check("t7_ww", words_written, 15'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t7_writes", wr_cnt - w0, 1);
    check("t7_queue_empty", exp_q.size(), 0);
    push(14'h0000, 32'h64636261, 4'b1111);
    do_start(14'h0000, 16'd4);
    stream(8'h61, 4, 1'b0);
    wait_done(20);
    check("t7b_ww", words_written, 15'd1);
    @(posedge clk); #1;

    // Source gaps with a start pulse while busy
    w0 = wr_cnt;
    push(14'h0300, 32'h73727170, 4'b1111);
    push(14'h0301, 32'h00767574, 4'b0111);
    do_start(14'h0300, 16'd7);
    fork
      stream(8'h70, 7, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        base_addr  = 14'h0055;
        byte_count = 16'd4;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
      end
    join
    wait_done(20);
    check("t8_ww", words_written, 15'd2);
    check("t8_err", err, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t8_busy_after", busy, 1'b0);
    check("t8_writes", wr_cnt - w0, 2);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/soc_system_mem_stream_writer.md
Name: soc_system_mem_stream_writer

Overview:
- Avalon-ST byte sink to Avalon-MM word-write master that fills the soc_system on-chip memory (32-bit words, 14-bit word address, 12288 words) from an 8-bit byte stream.
- Sits directly upstream of the memory's s1 slave.
- A control interface supplies base word address and byte count; bytes are packed little-endian into 32-bit words and written with byteenables, including a partial final word.

Parameters:
- ADDR_WIDTH, 14, word address width of target memory
- DEPTH, 12288, number of 32-bit words in target memory
- CNT_WIDTH, 16, width of byte_count (must hold DEPTH*4 = 49152)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled in IDLE only
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- byte_count  in  CNT_WIDTH  bytes to transfer, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at transfer end, successful or rejected
- err  out  1  sticky range error, cleared by the next accepted start
- words_written  out  ADDR_WIDTH+1  words committed in the current/last transfer
- snk_data  in  8  stream byte
- snk_valid  in  1  stream byte valid
- snk_ready  out  1  sink ready
- m_address  out  ADDR_WIDTH  memory word address
- m_byteenable  out  4  lane enables
- m_chipselect  out  1  memory select
- m_write  out  1  write strobe
- m_writedata  out  32  packed word
- m_waitrequest  in  1  interconnect stall; tie 0 for direct connection

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: busy=0, done=0, err=0, words_written=0, snk_ready=0, m_chipselect=0, m_write=0, m_byteenable=0, m_address=0, m_writedata=0; FSM=IDLE.
- Reset asserted mid-transfer takes effect at the next edge. Any pending write is dropped, and partially packed bytes are discarded.
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE, on start:
  - Let nwords = ceil(byte_count/4), computed at CNT_WIDTH+1 bits.
  - If byte_count==0: go to FINISH with err=0 and no writes.
  - If base_addr+nwords > DEPTH, compared unwidened at ADDR_WIDTH+2 bits: go to FINISH with err=1 and no writes.
  - Otherwise: latch base_addr and byte_count, clear err and words_written, set busy, go to COLLECT.
- COLLECT:
  - snk_ready=1. A byte is accepted on snk_valid&snk_ready.
  - Byte k of a word (k=0..3) goes to writedata[8k+7:8k] and sets byteenable bit k.
  - Remaining byte counter decrements per accepted byte.
  - After the 4th byte of a word, or when remaining reaches 0, go to WRITE; snk_ready is 0 from the next cycle.
- WRITE:
  - m_chipselect=m_write=1; address, data and byteenable are held stable while m_waitrequest=1.
  - The write completes on the first cycle with m_waitrequest=0. At that point: address+1, words_written+1, lane index and byteenable cleared, writedata cleared to 0.
  - Next state is FINISH if remaining==0, else COLLECT.
  - Unused lanes of a partial final word have byteenable=0 and data 0.
- FINISH: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency and throughput:
  - Minimum cost per full word is 4 accept cycles plus 1 write cycle.
  - The first snk_ready is 1 cycle after start.
  - done is 1 cycle after the last write completes.
- start while busy is ignored. byte_count/base_addr changes after start are ignored.
- No wrap-around: the last legal address is DEPTH-1; the range check guarantees m_address never exceeds it.
- snk_valid without snk_ready (IDLE/WRITE/FINISH): the byte is not consumed; the source holds it per Avalon-ST.

Test Plan:
- Full-word transfer:
  - Stimulus: start, base=0x0010, count=8; bytes 0x11..0x18 streamed continuously.
  - Response: write @0x0010 data 0x14131211 be=1111; write @0x0011 data 0x18171615 be=1111.
  - done pulse, words_written=2, err=0.
- Partial final word:
  - Stimulus: base=0x0100, count=6, bytes 0xA0..0xA5.
  - Response: second write @0x0101 data 0x0000A5A4 be=0011.
- Waitrequest stall:
  - Stimulus: m_waitrequest=1 for 3 cycles during the first write.
  - Response: address/data/be stable across all stalled cycles; snk_ready=0 throughout; exactly one write accepted.
- Range error and zero length:
  - Stimulus: base=0x2FFF, count=8.
  - Response: err=1, done 1 cycle after start, no m_write.
  - Then stimulus: start, base=0x2FFF, count=4.
  - Response: a single write @0x2FFF; err cleared.
  - Then stimulus: count=0.
  - Response: done with no writes.
- Reset mid-operation:
  - Stimulus: assert reset after 2 bytes of the 2nd word.
  - Response: next cycle all outputs at reset values; no further writes.
  - Then stimulus: a subsequent start with base=0, count=4.
  - Response: a clean single write.
- Source gaps and ignored start:
  - Stimulus: snk_valid toggles 1/0 every cycle; start pulses while busy.
  - Response: byte packing is unaffected; the second start is ignored; the words_written total is correct.
